uart_core_fc: RTL and testbench

Parametrised, flow-controlled UART core: the next generation of the team's UART top, with generic character width, FIFO depth and optional parity folded into one block. It adds RTS/CTS hardware flow control, an RX idle-timeout flag, per-character error tagging and sticky overrun status. It sits between the bus register interface and the pads: one TX and one RX serial line, 16x oversampling.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_core_fc.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_uart_core_fc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the flow-controlled UART core.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam int unsigned ST_TX_FULL    = 0;
    localparam int unsigned ST_TX_EMPTY   = 1;
    localparam int unsigned ST_RX_FULL    = 2;
    localparam int unsigned ST_RX_EMPTY   = 3;
    localparam int unsigned ST_RX_OVERRUN = 4;
    localparam int unsigned ST_RX_TIMEOUT = 5;
    localparam int unsigned ST_TX_BUSY    = 6;
    localparam int unsigned ST_CTS_STALL  = 7;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BRK_WAIT
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; a write on a full FIFO succeeds
// only when a read is accepted in the same cycle.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      level_q;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rptr_q];
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_wr) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_rd) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_core_fc.sv
// UART core with TX/RX FIFOs, optional parity, RTS/CTS flow control,
// RX idle timeout and sticky overrun/timeout status.
module uart_core_fc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_AW    = 4,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned RTS_THRESH = 2 ** FIFO_AW - 2,
    parameter int unsigned TOUT_BITS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_en,
    input  logic [15:0]       uart_baudgen,
    input  logic              uart_write,
    input  logic [DATA_W-1:0] uart_data_write,
    input  logic              uart_read,
    input  logic              uart_clr,
    output logic [DATA_W-1:0] uart_data_read,
    output logic [1:0]        uart_rx_err,
    output logic [7:0]        uart_status,
    output logic [FIFO_AW:0]  uart_tx_level,
    output logic [FIFO_AW:0]  uart_rx_level,
    input  logic              rx,
    input  logic              cts_n,
    output logic              tx,
    output logic              rts_n
);

    localparam logic [3:0]     LAST_TICK  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]     HALF_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]     LAST_BIT   = 4'(DATA_W - 1);
    localparam int unsigned    TOUT_TICKS = TOUT_BITS * OVERSAMPLE;
    localparam int unsigned    TW         = $clog2(TOUT_TICKS + 1);
    localparam logic [FIFO_AW:0] RTS_LVL  = (FIFO_AW+1)'(RTS_THRESH);
    localparam logic           ODD        = (PARITY_ODD != 0);

    // Baud generator
    logic [15:0] baud_q, baud_d;
    logic        tick;

    always_comb begin
        baud_d = baud_q + 16'd1;
        tick   = 1'b0;
        if (!uart_en) begin
            baud_d = '0;
        end else if (baud_q >= uart_baudgen) begin
            baud_d = '0;
            tick   = 1'b1;
        end
    end

    // Synchronisers
    logic [1:0] rx_sync_q, cts_sync_q;
    logic       rx_s, cts_s;
    assign rx_s  = rx_sync_q[1];
    assign cts_s = cts_sync_q[1];

    // FIFOs
    logic                tx_full, tx_empty, tx_pop;
    logic [DATA_W-1:0]   tx_head;
    logic                rx_full, rx_empty, rx_push;
    logic [DATA_W+1:0]   rx_head, rx_word;

    uart_sync_fifo #(.WIDTH(DATA_W), .AW(FIFO_AW)) u_tx_fifo (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (uart_write),
        .wr_data (uart_data_write),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .level   (uart_tx_level)
    );

    uart_sync_fifo #(.WIDTH(DATA_W + 2), .AW(FIFO_AW)) u_rx_fifo (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (rx_push),
        .wr_data (rx_word),
        .rd_en   (uart_read),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .level   (uart_rx_level)
    );

    // RX FSM
    rx_state_t         rx_state_q, rx_state_d;
    logic [3:0]        rx_tick_q, rx_tick_d;
    logic [3:0]        rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rx_par_q, rx_par_d;
    logic              start_det;
    logic              par_err;

    assign par_err = (PARITY_EN != 0) && ((^rx_shift_q ^ rx_par_q) != ODD);
    assign rx_word = {par_err, !rx_s, rx_shift_q};

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_push    = 1'b0;
        start_det  = 1'b0;
        if (!uart_en) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_state_d = RX_START;
                        rx_tick_d  = '0;
                        start_det  = 1'b1;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        rx_tick_d = rx_tick_q + 4'd1;
                        if (rx_tick_q == HALF_TICK) begin
                            rx_tick_d  = '0;
                            rx_bit_d   = '0;
                            rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rx_tick_d = rx_tick_q + 4'd1;
                        if (rx_tick_q == LAST_TICK) begin
                            rx_shift_d = {rx_s, rx_shift_q[DATA_W-1:1]};
                            rx_bit_d   = rx_bit_q + 4'd1;
                            if (rx_bit_q == LAST_BIT) begin
                                rx_state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                            end
                        end
                    end
                end
                RX_PARITY: begin
                    if (tick) begin
                        rx_tick_d = rx_tick_q + 4'd1;
                        if (rx_tick_q == LAST_TICK) begin
                            rx_par_d   = rx_s;
                            rx_state_d = RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        rx_tick_d = rx_tick_q + 4'd1;
                        if (rx_tick_q == LAST_TICK) begin
                            rx_push    = 1'b1;
                            rx_state_d = rx_s ? RX_IDLE : RX_BRK_WAIT;
                        end
                    end
                end
                RX_BRK_WAIT: begin
                    if (rx_s) begin
                        rx_state_d = RX_IDLE;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    // TX FSM
    tx_state_t         tx_state_q, tx_state_d;
    logic [3:0]        tx_tick_q, tx_tick_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_par_q, tx_par_d;
    logic              tx_q, tx_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        if (!uart_en) begin
            tx_state_d = TX_IDLE;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tick && !tx_empty && !cts_s) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_par_d   = ^tx_head ^ ODD;
                        tx_tick_d  = '0;
                        tx_bit_d   = '0;
                        tx_state_d = TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        tx_tick_d = tx_tick_q + 4'd1;
                        if (tx_tick_q == LAST_TICK) begin
                            tx_state_d = TX_DATA;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        tx_tick_d = tx_tick_q + 4'd1;
                        if (tx_tick_q == LAST_TICK) begin
                            tx_shift_d = tx_shift_q >> 1;
                            tx_bit_d   = tx_bit_q + 4'd1;
                            if (tx_bit_q == LAST_BIT) begin
                                tx_state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                            end
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick) begin
                        tx_tick_d = tx_tick_q + 4'd1;
                        if (tx_tick_q == LAST_TICK) begin
                            tx_state_d = TX_STOP;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        tx_tick_d = tx_tick_q + 4'd1;
                        if (tx_tick_q == LAST_TICK) begin
                            tx_state_d = TX_IDLE;
                        end
                    end
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end
        // Line level follows the next state so tx changes on the same edge as the FSM.
        case (tx_state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_shift_d[0];
            TX_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // Sticky flags and idle timeout
    logic          ovr_q, ovr_d;
    logic          tmo_q, tmo_d;
    logic [TW-1:0] tout_q, tout_d;
    logic          tout_set;
    logic          rts_q;

    always_comb begin
        tout_d   = tout_q;
        tout_set = 1'b0;
        if ((rx_state_q != RX_IDLE) || start_det || uart_read || rx_empty) begin
            tout_d = '0;
        end else if (tick && (tout_q != TW'(TOUT_TICKS))) begin
            tout_d   = tout_q + TW'(1);
            tout_set = (tout_q == TW'(TOUT_TICKS - 1));
        end
        ovr_d = ovr_q;
        if (rx_push && rx_full && !uart_read) begin
            ovr_d = 1'b1;
        end else if (uart_clr) begin
            ovr_d = 1'b0;
        end
        tmo_d = tmo_q;
        if (tout_set) begin
            tmo_d = 1'b1;
        end else if (uart_clr || uart_read) begin
            tmo_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_q     <= '0;
            rx_sync_q  <= '1;
            cts_sync_q <= '1;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            ovr_q      <= 1'b0;
            tmo_q      <= 1'b0;
            tout_q     <= '0;
            rts_q      <= 1'b0;
        end else begin
            baud_q     <= baud_d;
            rx_sync_q  <= {rx_sync_q[0], rx};
            cts_sync_q <= {cts_sync_q[0], cts_n};
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            ovr_q      <= ovr_d;
            tmo_q      <= tmo_d;
            tout_q     <= tout_d;
            rts_q      <= (uart_rx_level >= RTS_LVL);
        end
    end

    assign tx             = tx_q;
    assign rts_n          = rts_q;
    assign uart_data_read = rx_empty ? '0 : rx_head[DATA_W-1:0];
    assign uart_rx_err    = rx_empty ? '0 : rx_head[DATA_W+1:DATA_W];

    always_comb begin
        uart_status                = '0;
        uart_status[ST_TX_FULL]    = tx_full;
        uart_status[ST_TX_EMPTY]   = tx_empty;
        uart_status[ST_RX_FULL]    = rx_full;
        uart_status[ST_RX_EMPTY]   = rx_empty;
        uart_status[ST_RX_OVERRUN] = ovr_q;
        uart_status[ST_RX_TIMEOUT] = tmo_q;
        uart_status[ST_TX_BUSY]    = (tx_state_q != TX_IDLE);
        uart_status[ST_CTS_STALL]  = !tx_empty && cts_s && (tx_state_q == TX_IDLE);
    end

endmodule

// File: tb/tb_uart_core_fc.sv
// Scoreboarded bench: u_dut (8N1, loopback or injected RX) and u_par (8E1, injected RX).
module tb_uart_core_fc;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, uart_en;
    logic [15:0] baudgen;
    logic       wr0, rd0, clr0, rd1;
    logic [7:0] wdata0, rdata0, rdata1, st0, st1;
    logic [1:0] err0, err1;
    logic [4:0] txl0, rxl0, txl1, rxl1;
    logic       rx0, cts0, tx0, rts0, rx1, tx1, rts1;
    logic       loopback, rx_drv;

    assign rx0 = loopback ? tx0 : rx_drv;

    uart_core_fc #(.DATA_W(8), .FIFO_AW(4), .PARITY_EN(0)) u_dut (
        .clk(clk), .reset(reset), .uart_en(uart_en), .uart_baudgen(baudgen),
        .uart_write(wr0), .uart_data_write(wdata0), .uart_read(rd0), .uart_clr(clr0),
        .uart_data_read(rdata0), .uart_rx_err(err0), .uart_status(st0),
        .uart_tx_level(txl0), .uart_rx_level(rxl0),
        .rx(rx0), .cts_n(cts0), .tx(tx0), .rts_n(rts0)
    );

    uart_core_fc #(.DATA_W(8), .FIFO_AW(4), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .reset(reset), .uart_en(uart_en), .uart_baudgen(baudgen),
        .uart_write(1'b0), .uart_data_write(8'h00), .uart_read(rd1), .uart_clr(1'b0),
        .uart_data_read(rdata1), .uart_rx_err(err1), .uart_status(st1),
        .uart_tx_level(txl1), .uart_rx_level(rxl1),
        .rx(rx1), .cts_n(1'b1), .tx(tx1), .rts_n(rts1)
    );

    int errors = 0;
    int checks = 0;
    logic [9:0] exp0[$];
    logic [9:0] exp1[$];
    bit auto0 = 1'b0;
    bit auto1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: whenever a receiver presents a character, compare it to the queue head and pop it.
    initial begin
        rd0 = 1'b0;
        rd1 = 1'b0;
        forever begin
            @(negedge clk);
            rd0 = 1'b0;
            rd1 = 1'b0;
            if (reset === 1'b0 && auto0 && !st0[ST_RX_EMPTY]) begin
                if (exp0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx0_extra: got 0x%0h expected nothing", {err0, rdata0});
                end else begin
                    check("rx0_head", 32'({err0, rdata0}), 32'(exp0.pop_front()));
                end
                rd0 = 1'b1;
            end
            if (reset === 1'b0 && auto1 && !st1[ST_RX_EMPTY]) begin
                if (exp1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx1_extra: got 0x%0h expected nothing", {err1, rdata1});
                end else begin
                    check("rx1_head", 32'({err1, rdata1}), 32'(exp1.pop_front()));
                end
                rd1 = 1'b1;
            end
        end
    end

    task automatic write0(input logic [7:0] d);
        wdata0 = d;
        wr0    = 1'b1;
        @(negedge clk);
        wr0    = 1'b0;
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx_drv = v;
        else            rx1    = v;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit par_en,
                              input logic p, input logic stop, input int stop_len);
        set_rx(which, 1'b0);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, d[i]);
            repeat (16) @(negedge clk);
        end
        if (par_en) begin
            set_rx(which, p);
            repeat (16) @(negedge clk);
        end
        set_rx(which, stop);
        repeat (stop_len) @(negedge clk);
    endtask

    int n, n_lo, n_fr;
    bit seen_hi, stay;
    logic [7:0] c;

    initial begin
        reset = 1'b1; uart_en = 1'b1; baudgen = 16'd0;
        wr0 = 1'b0; wdata0 = 8'h00; clr0 = 1'b0; cts0 = 1'b0;
        loopback = 1'b1; rx_drv = 1'b1; rx1 = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_tx", 32'(tx0), 32'd1);
        check("rst_rts", 32'(rts0), 32'd0);
        check("rst_status", 32'(st0), 32'h0A);
        check("rst_txlvl", 32'(txl0), 32'd0);
        check("rst_rxlvl", 32'(rxl0), 32'd0);
        check("rst_rdata", 32'({err0, rdata0}), 32'd0);
        check("rst_status_par", 32'(st1), 32'h0A);

        // Loopback 8N1
        auto0 = 1'b1;
        exp0.push_back({2'b00, 8'hA5});
        write0(8'hA5);
        check("lb_txlvl", 32'(txl0), 32'd1);
        n = 0;
        while (tx0 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        n_lo = 0; n_fr = 0; seen_hi = 1'b0;
        while (st0[ST_TX_BUSY] && n_fr < 400) begin
            if (tx0) seen_hi = 1'b1;
            else if (!seen_hi) n_lo++;
            n_fr++;
            @(negedge clk);
        end
        check("lb_start_len", 32'(n_lo), 32'd16);
        check("lb_frame_len", 32'(n_fr), 32'd160);
        exp0.push_back({2'b00, 8'h3C});
        write0(8'h3C);
        n = 0;
        while ((exp0.size() != 0 || st0[ST_TX_BUSY]) && n < 1000) begin @(negedge clk); n++; end
        check("lb_drain", 32'(exp0.size()), 32'd0);

        // CTS flow control
        cts0 = 1'b1;
        repeat (4) @(negedge clk);
        exp0.push_back({2'b00, 8'h11}); write0(8'h11);
        exp0.push_back({2'b00, 8'h22}); write0(8'h22);
        exp0.push_back({2'b00, 8'h33}); write0(8'h33);
        stay = 1'b1;
        repeat (50) begin if (!tx0) stay = 1'b0; @(negedge clk); end
        check("cts_hold_tx", 32'(stay), 32'd1);
        check("cts_stall", 32'(st0[ST_CTS_STALL]), 32'd1);
        check("cts_txlvl3", 32'(txl0), 32'd3);
        cts0 = 1'b0;
        n = 0;
        while (tx0 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        check("cts_go", 32'(tx0), 32'd0);
        repeat (40) @(negedge clk);
        cts0 = 1'b1;
        n = 0;
        while (st0[ST_TX_BUSY] && n < 300) begin @(negedge clk); n++; end
        stay = 1'b1;
        repeat (200) begin if (!tx0) stay = 1'b0; @(negedge clk); end
        check("cts_hold_after", 32'(stay), 32'd1);
        check("cts_txlvl2", 32'(txl0), 32'd2);
        check("cts_stall2", 32'(st0[ST_CTS_STALL]), 32'd1);
        check("cts_one_char", 32'(exp0.size()), 32'd2);
        cts0 = 1'b0;
        n = 0;
        while ((exp0.size() != 0 || st0[ST_TX_BUSY] || txl0 != 0) && n < 1000) begin @(negedge clk); n++; end
        check("cts_drain", 32'(exp0.size()), 32'd0);

        // Overrun and RTS
        loopback = 1'b0; auto0 = 1'b0;
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 17; k++) begin
            c = 8'h10 + 8'(k);
            if (k <= 16) exp0.push_back({2'b00, c});
            send_frame(0, c, 1'b0, 1'b0, 1'b1, 16);
            if (k == 13) begin @(negedge clk); check("rts_below", 32'(rts0), 32'd0); end
            if (k == 14) begin @(negedge clk); check("rts_at_thresh", 32'(rts0), 32'd1); end
        end
        @(negedge clk);
        check("ovr_full", 32'(st0[ST_RX_FULL]), 32'd1);
        check("ovr_flag", 32'(st0[ST_RX_OVERRUN]), 32'd1);
        check("ovr_level", 32'(rxl0), 32'd16);
        check("ovr_head", 32'(rdata0), 32'h11);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        check("ovr_cleared", 32'(st0[ST_RX_OVERRUN]), 32'd0);
        auto0 = 1'b1;
        n = 0;
        while (exp0.size() != 0 && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check("ovr_drain", 32'(exp0.size()), 32'd0);
        check("ovr_rx_empty", 32'(st0[ST_RX_EMPTY]), 32'd1);

        // RX idle timeout
        auto0 = 1'b0;
        repeat (10) @(negedge clk);
        exp0.push_back({2'b00, 8'h5A});
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 0);
        n = 0;
        while (rxl0 != 5'd1 && n < 40) begin @(negedge clk); n++; end
        check("tmo_char_in", 32'(rxl0), 32'd1);
        n = 0;
        while (!st0[ST_RX_TIMEOUT] && n < 600) begin n++; @(negedge clk); end
        check("tmo_latency", 32'(n), 32'd512);
        auto0 = 1'b1;
        n = 0;
        while (exp0.size() != 0 && n < 20) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check("tmo_cleared", 32'(st0[ST_RX_TIMEOUT]), 32'd0);

        // Parity error, framing error with break
        auto1 = 1'b1;
        exp1.push_back({2'b10, 8'h01});
        send_frame(1, 8'h01, 1'b1, 1'b0, 1'b1, 16);
        exp1.push_back({2'b01, 8'h55});
        send_frame(1, 8'h55, 1'b1, 1'b0, 1'b0, 400);
        check("brk_state", 32'(u_par.rx_state_q), 32'(RX_BRK_WAIT));
        check("brk_no_push", 32'(rxl1), 32'd0);
        check("brk_consumed", 32'(exp1.size()), 32'd0);
        rx1 = 1'b1;
        repeat (32) @(negedge clk);
        exp1.push_back({2'b00, 8'h7E});
        send_frame(1, 8'h7E, 1'b1, 1'b0, 1'b1, 16);
        n = 0;
        while (exp1.size() != 0 && n < 40) begin @(negedge clk); n++; end
        check("par_drain", 32'(exp1.size()), 32'd0);

        // Asynchronous reset during a TX data bit
        loopback = 1'b1;
        write0(8'hF0);
        n = 0;
        while (tx0 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        repeat (30) @(negedge clk);
        check("amid_tx_low", 32'(tx0), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("amid_tx", 32'(tx0), 32'd1);
        check("amid_status", 32'(st0), 32'h0A);
        check("amid_txlvl", 32'(txl0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("amid_no_rx", 32'(st0[ST_RX_EMPTY]), 32'd1);
        check("final_q0", 32'(exp0.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
